stream_upsize_arb: RTL and testbench

//  Packet-level round-robin arbiter that shares one stream_upsize instance between N narrow source streams.

---
 rtl/stream_upsize_arb.sv | 136 +++++++++++++
 tb/tb_stream_upsize_arb.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_upsize_arb.sv
`default_nettype none
// ============================================================================
// Module   : stream_upsize_arb
// Purpose  : Packet-level round-robin arbiter sharing one stream_upsize slave
//            port between N_SRC narrow sources. Optional macro
//            STREAM_ARB_PKT_CNT_EN adds saturating per-source packet counters.
// Revision : 1.0 - initial release
// ============================================================================
module stream_upsize_arb #(
  parameter int T_DATA_WIDTH = 4,
  parameter int N_SRC        = 4,
  parameter int CNT_W        = 16,
  localparam int ID_W        = $clog2(N_SRC)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [T_DATA_WIDTH-1:0] s_data_i [N_SRC-1:0],
  input  logic [N_SRC-1:0]        s_last_i,
  input  logic [N_SRC-1:0]        s_valid_i,
  output logic [N_SRC-1:0]        s_ready_o,
  output logic [T_DATA_WIDTH-1:0] m_data_o,
  output logic                    m_last_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i,
  output logic [ID_W-1:0]         m_id_o,
  output logic                    busy_o
`ifdef STREAM_ARB_PKT_CNT_EN
  ,
  output logic [CNT_W-1:0]        pkt_cnt_o [N_SRC-1:0]
`endif
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  generate
    if (N_SRC < 2 || CNT_W < 1) begin : g_param_chk
      $error("stream_upsize_arb: N_SRC must be >= 2 and CNT_W >= 1");
    end
  endgenerate

  state_t          r_state;
  state_t          w_state_nxt;
  logic [ID_W-1:0] r_grant;
  logic [ID_W-1:0] w_grant_nxt;
  logic [ID_W-1:0] r_rr_ptr;
  logic [ID_W-1:0] w_rr_ptr_nxt;
  logic [ID_W-1:0] w_pick;
  logic            w_found;
  int              w_idx;
  logic            w_hs_last;

  // Round-robin search starting at r_rr_ptr, wrapping at N_SRC (not 2**ID_W).
  always_comb begin
    w_pick  = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int i = 0; i < N_SRC; i++) begin
      w_idx = int'(r_rr_ptr) + i;
      if (w_idx >= N_SRC) begin
        w_idx = w_idx - N_SRC;
      end
      if (!w_found && s_valid_i[w_idx[ID_W-1:0]]) begin
        w_pick  = w_idx[ID_W-1:0];
        w_found = 1'b1;
      end
    end
  end

  assign w_hs_last = (r_state == ST_BUSY) & s_valid_i[r_grant] & m_ready_i & s_last_i[r_grant];
  assign m_id_o    = r_grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_rr_ptr_nxt = r_rr_ptr;
    m_data_o     = s_data_i[r_grant];
    m_last_o     = s_last_i[r_grant];
    m_valid_o    = 1'b0;
    s_ready_o    = '0;
    busy_o       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_grant_nxt = w_pick;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // Ready depends only on m_ready_i, never on any s_valid_i.
        busy_o             = 1'b1;
        m_valid_o          = s_valid_i[r_grant];
        s_ready_o[r_grant] = m_ready_i;
        if (w_hs_last) begin
          w_state_nxt  = ST_IDLE;
          w_rr_ptr_nxt = (r_grant == ID_W'(N_SRC - 1)) ? '0 : r_grant + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

`ifdef STREAM_ARB_PKT_CNT_EN
  logic [CNT_W-1:0] r_pkt_cnt [N_SRC-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_SRC; i++) begin
        r_pkt_cnt[i] <= '0;
      end
    end else if (w_hs_last && (r_pkt_cnt[r_grant] != {CNT_W{1'b1}})) begin
      r_pkt_cnt[r_grant] <= r_pkt_cnt[r_grant] + 1'b1;
    end
  end

  assign pkt_cnt_o = r_pkt_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stream_upsize_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_upsize_arb
// Purpose  : Directed self-checking bench for stream_upsize_arb (N_SRC=4,
//            CNT_W=2; counter test active with STREAM_ARB_PKT_CNT_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_upsize_arb;

  localparam int DW = 4;
  localparam int NS = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_data [NS-1:0];
  logic [NS-1:0] s_last;
  logic [NS-1:0] s_valid;
  logic [NS-1:0] s_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          m_valid;
  logic          m_ready;
  logic [1:0]    m_id;
  logic          busy;
`ifdef STREAM_ARB_PKT_CNT_EN
  logic [CW-1:0] pkt_cnt [NS-1:0];
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  stream_upsize_arb #(
    .T_DATA_WIDTH(DW),
    .N_SRC       (NS),
    .CNT_W       (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s_data_i (s_data),
    .s_last_i (s_last),
    .s_valid_i(s_valid),
    .s_ready_o(s_ready),
    .m_data_o (m_data),
    .m_last_o (m_last),
    .m_valid_o(m_valid),
    .m_ready_i(m_ready),
    .m_id_o   (m_id),
    .busy_o   (busy)
`ifdef STREAM_ARB_PKT_CNT_EN
    ,
    .pkt_cnt_o(pkt_cnt)
`endif
  );

  // Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    s_valid = 4'hF;
    s_last  = 4'h0;
    m_ready = 1'b1;
    for (int i = 0; i < NS; i++) s_data[i] = 4'(i);
    tick();
    tick();
    n_tests++;
    if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
    n_tests++;
    if (s_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_s_ready: got %b want 0000", s_ready); end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++;
    if (m_id !== 2'd0) begin n_fail++; $display("FAIL reset_m_id: got %0d want 0", m_id); end
    rst = 1'b0;
    tick();
    n_tests++;
    if (busy !== 1'b1 || m_id !== 2'd0 || s_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_first_grant: busy=%b id=%0d ready=%b want busy=1 id=0 ready=0001", busy, m_id, s_ready);
    end
  endtask

  task automatic test_fairness();
    int beats [NS];
    int id;
    logic [DW-1:0] exp_d;
    do_reset();
    s_valid = 4'hF;
    m_ready = 1'b1;
    for (int i = 0; i < NS; i++) beats[i] = 0;
    for (int p = 0; p < 6; p++) begin
      id = p % NS;
      n_tests++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL fair_idle_bubble p%0d: busy=%b want 0", p, busy); end
      tick();
      n_tests++;
      if (busy !== 1'b1 || m_id !== 2'(id)) begin
        n_fail++;
        $display("FAIL fair_grant p%0d: busy=%b id=%0d want busy=1 id=%0d", p, busy, m_id, id);
      end
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < NS; i++) begin
          s_last[i] = (beats[i] == 1);
          s_data[i] = {2'(i), 2'(beats[i])};
        end
        #1;
        exp_d = {2'(id), 2'(b)};
        n_tests++;
        if (m_data !== exp_d || m_valid !== 1'b1 || m_last !== (b == 1)) begin
          n_fail++;
          $display("FAIL fair_beat p%0d b%0d: data=%h valid=%b last=%b want data=%h valid=1 last=%0d",
                   p, b, m_data, m_valid, m_last, exp_d, (b == 1));
        end
        tick();
        beats[id] = (beats[id] + 1) % 2;
      end
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] beat_v [3];
    logic [4:0]    rdy_pat;
    int            k;
    beat_v[0] = 4'hA;
    beat_v[1] = 4'hB;
    beat_v[2] = 4'hC;
    rdy_pat   = 5'b10101;
    do_reset();
    s_valid = 4'b0100;
    s_last  = 4'b0000;
    m_ready = 1'b0;
    s_data[2] = beat_v[0];
    tick();
    n_tests++;
    if (m_id !== 2'd2) begin n_fail++; $display("FAIL bp_grant: id=%0d want 2", m_id); end
    k = 0;
    for (int c = 0; c < 5; c++) begin
      s_data[2] = beat_v[k];
      s_last[2] = (k == 2);
      m_ready   = rdy_pat[c];
      #1;
      n_tests++;
      if (m_data !== beat_v[k] || s_ready !== (m_ready ? 4'b0100 : 4'b0000)) begin
        n_fail++;
        $display("FAIL bp_cycle%0d: data=%h ready=%b want data=%h ready=%b",
                 c, m_data, s_ready, beat_v[k], (m_ready ? 4'b0100 : 4'b0000));
      end
      tick();
      if (rdy_pat[c]) k++;
    end
    n_tests++;
    if (k !== 3 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_done: accepted=%0d busy=%b want accepted=3 busy=0", k, busy);
    end
    m_ready = 1'b1;
    s_valid = 4'b0000;
  endtask

  task automatic test_no_preempt();
    do_reset();
    s_valid = 4'b1000;
    s_last  = 4'b0000;
    m_ready = 1'b1;
    tick();
    n_tests++;
    if (m_id !== 2'd3) begin n_fail++; $display("FAIL np_grant3: id=%0d want 3", m_id); end
    tick();
    s_valid = 4'b1001;
    #1;
    n_tests++;
    if (s_ready !== 4'b1000) begin n_fail++; $display("FAIL np_mid_ready: got %b want 1000", s_ready); end
    tick();
    s_last[3] = 1'b1;
    #1;
    n_tests++;
    if (s_ready !== 4'b1000 || m_last !== 1'b1) begin
      n_fail++;
      $display("FAIL np_last_ready: ready=%b last=%b want 1000 1", s_ready, m_last);
    end
    tick();
    s_last = 4'b0000;
    n_tests++;
    if (busy !== 1'b0 || s_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL np_bubble: busy=%b ready=%b want 0 0000", busy, s_ready);
    end
    tick();
    n_tests++;
    if (m_id !== 2'd0 || s_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL np_wrap_grant: id=%0d ready=%b want 0 0001", m_id, s_ready);
    end
    s_valid = 4'b0000;
  endtask

  task automatic test_valid_gap();
    do_reset();
    s_valid = 4'b0010;
    s_last  = 4'b0000;
    m_ready = 1'b1;
    tick();
    tick();
    s_valid = 4'b1101;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_tests++;
      if (busy !== 1'b1 || m_valid !== 1'b0 || m_id !== 2'd1 || s_ready !== 4'b0010) begin
        n_fail++;
        $display("FAIL gap_cycle%0d: busy=%b valid=%b id=%0d ready=%b want 1 0 1 0010",
                 c, busy, m_valid, m_id, s_ready);
      end
      tick();
    end
    s_valid = 4'b1111;
    s_last  = 4'b0010;
    #1;
    n_tests++;
    if (m_valid !== 1'b1 || m_id !== 2'd1) begin
      n_fail++;
      $display("FAIL gap_resume: valid=%b id=%0d want 1 1", m_valid, m_id);
    end
    tick();
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL gap_end: busy=%b want 0", busy); end
    s_valid = 4'b0000;
    s_last  = 4'b0000;
  endtask

`ifdef STREAM_ARB_PKT_CNT_EN
  task automatic test_pkt_cnt();
    logic [CW-1:0] exp_c [5];
    exp_c[0] = 2'd1; exp_c[1] = 2'd2; exp_c[2] = 2'd3; exp_c[3] = 2'd3; exp_c[4] = 2'd3;
    do_reset();
    m_ready = 1'b1;
    s_last  = 4'b0010;
    for (int p = 0; p < 5; p++) begin
      s_valid = 4'b0010;
      tick();
      tick();
      s_valid = 4'b0000;
      n_tests++;
      if (pkt_cnt[1] !== exp_c[p] || pkt_cnt[0] !== 2'd0 || pkt_cnt[2] !== 2'd0 || pkt_cnt[3] !== 2'd0) begin
        n_fail++;
        $display("FAIL cnt_pkt%0d: cnt=%0d/%0d/%0d/%0d want 0/%0d/0/0",
                 p, pkt_cnt[0], pkt_cnt[1], pkt_cnt[2], pkt_cnt[3], exp_c[p]);
      end
    end
    s_valid = 4'b0010;
    s_last  = 4'b0000;
    tick();
    rst = 1'b1;
    #1;
    n_tests++;
    if (pkt_cnt[1] !== 2'd0 || busy !== 1'b0 || m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL cnt_rst: cnt1=%0d busy=%b valid=%b want 0 0 0", pkt_cnt[1], busy, m_valid);
    end
    tick();
    rst     = 1'b0;
    s_valid = 4'b0000;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst     = 1'b1;
    s_valid = '0;
    s_last  = '0;
    m_ready = 1'b0;
    for (int i = 0; i < NS; i++) s_data[i] = '0;
    #1;
    test_reset();
    test_fairness();
    test_backpressure();
    test_no_preempt();
    test_valid_gap();
`ifdef STREAM_ARB_PKT_CNT_EN
    test_pkt_cnt();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
